// File: rtl/btn_capture_pkg.sv
// Shared definitions for the button event capture slice: status-word field
// layout, reset value and small helpers for counting and packing.
package btn_capture_pkg;

    // Each status-word field is fixed at four bits regardless of button count
    localparam int FIELD_BITS = 4;

    // Bit offsets of the fields inside the 16-bit status word
    localparam int STABLE_LSB = 0;
    localparam int STICKY_LSB = 4;
    localparam int CNT_LSB    = 8;

    // Width of the press counter field
    localparam int CNT_BITS   = 8;

    // Status word seen by the host straight after reset
    localparam logic [15:0] STATUS_RST = 16'h0000;

    // Layout of the word handed to the WireOut, MSB first
    typedef struct packed {
        logic [CNT_BITS-1:0]   press_cnt;
        logic [FIELD_BITS-1:0] sticky;
        logic [FIELD_BITS-1:0] stable;
    } status_t;

    // Number of events asserted in one cycle, sized to add onto the press counter
    function automatic logic [CNT_BITS-1:0] count_events(input logic [FIELD_BITS-1:0] ev);
        logic [CNT_BITS-1:0] total;
        total = '0;
        for (int i = 0; i < FIELD_BITS; i++) begin
            total = total + {{(CNT_BITS-1){1'b0}}, ev[i]};
        end
        return total;
    endfunction

    // Assemble the host-visible status word from its three fields
    function automatic logic [15:0] pack_status(input logic [CNT_BITS-1:0]   press_cnt,
                                                input logic [FIELD_BITS-1:0] sticky,
                                                input logic [FIELD_BITS-1:0] stable);
        status_t st;
        st.press_cnt = press_cnt;
        st.sticky    = sticky;
        st.stable    = stable;
        return st;
    endfunction

endpackage

// File: rtl/btn_event_capture_if.sv
// Button capture bus: raw buttons and host clear level going in, debounced
// state and the packed status word coming out.
interface btn_event_capture_if #(
    parameter int N_BTN = 4
);

    logic [N_BTN-1:0] btn_n;
    logic             clear_req;
    logic [N_BTN-1:0] stable;
    logic [15:0]      status_word;

    // Board/host side: drives the buttons and the clear request, reads status
    modport master (
        output btn_n,
        output clear_req,
        input  stable,
        input  status_word
    );

    // Capture block side
    modport slave (
        input  btn_n,
        input  clear_req,
        output stable,
        output status_word
    );

endinterface

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchroniser, debounce counter and stable flop.
// Emits a one-cycle event on the edge where stable is rewritten.
// Build option BTN_RELEASE_EVENT_EN: release transitions also produce events.
module btn_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNT_W           = 19
) (
    input  logic ti_clk,
    input  logic reset,
    input  logic btn_n,
    output logic stable,
    output logic evt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             pressed;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // Two-flop synchroniser; reset to released so nothing looks pressed at start-up
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    // Stable only flips once the synchronised input has disagreed for the full window
    always_comb begin
        flip = (pressed != stable) && (cnt == CNT_MAX);
    end

    // Count consecutive disagreeing cycles; any agreement restarts the window
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (pressed == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Debounced state register, written only when the window completes
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            stable <= 1'b0;
        end else if (flip) begin
            stable <= pressed;
        end
    end

`ifdef BTN_RELEASE_EVENT_EN
    assign evt = flip;
`else
    assign evt = flip & pressed;
`endif

endmodule

// File: rtl/btn_event_capture.sv
// Debounces active-low board buttons, latches sticky events and counts them
// for the host status WireOut. Host clears via rising edge of clear_req.
// Build option BTN_RELEASE_EVENT_EN: releases count as events as well as presses.
module btn_event_capture
    import btn_capture_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNT_W           = 19
) (
    input  logic ti_clk,
    input  logic reset,
    btn_event_capture_if.slave bus
);

    logic [N_BTN-1:0]      stable_int;
    logic [N_BTN-1:0]      evt;
    logic [N_BTN-1:0]      sticky;
    logic [CNT_BITS-1:0]   press_cnt;
    logic                  clear_req_q;
    logic                  clear_pulse;
    logic [FIELD_BITS-1:0] evt_nib;
    logic [FIELD_BITS-1:0] sticky_nib;
    logic [FIELD_BITS-1:0] stable_nib;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .ti_clk (ti_clk),
            .reset  (reset),
            .btn_n  (bus.btn_n[i]),
            .stable (stable_int[i]),
            .evt    (evt[i])
        );
    end

    // clear_req already comes from a ti_clk WireIn, so one flop is enough for edge detect
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            clear_req_q <= 1'b0;
        end else begin
            clear_req_q <= bus.clear_req;
        end
    end

    assign clear_pulse = bus.clear_req & ~clear_req_q;

    // Widen per-button vectors to the fixed 4-bit fields; unused bits read zero
    always_comb begin
        evt_nib    = '0;
        sticky_nib = '0;
        stable_nib = '0;
        evt_nib[N_BTN-1:0]    = evt;
        sticky_nib[N_BTN-1:0] = sticky;
        stable_nib[N_BTN-1:0] = stable_int;
    end

    // Sticky events: a clear and a new event in the same cycle keep the event
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= (clear_pulse ? '0 : sticky) | evt;
        end
    end

    // Event counter wraps freely; simultaneous events all add in one cycle
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            press_cnt <= STATUS_RST[CNT_LSB +: CNT_BITS];
        end else begin
            press_cnt <= (clear_pulse ? '0 : press_cnt) + count_events(evt_nib);
        end
    end

    assign bus.stable      = stable_int;
    assign bus.status_word = pack_status(press_cnt, sticky_nib, stable_nib);

endmodule

// File: tb/tb_btn_event_capture.sv
// Self-checking bench for btn_event_capture with an 8-cycle debounce window.
// A window-based reference model predicts the status word every cycle.
module tb_btn_event_capture;

    localparam int WIN = 8;

    logic       ti_clk = 1'b0;
    logic       reset;
    logic [3:0] btn_drv;
    logic       clear_drv;

    int vec_count  = 0;
    int miss_count = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  raw_q[$];
    logic [3:0]  m_stable;
    logic [3:0]  m_sticky;
    logic [7:0]  m_cnt;
    logic        m_clr_prev;
    logic [3:0]  m_flip;
    logic [3:0]  m_evt;
    bit          m_armed = 0;
    bit          all_diff;
    int          n_raw;
    int          idx;
    logic [15:0] mon_exp;

    always #5 ti_clk = ~ti_clk;

    btn_event_capture_if #(.N_BTN(4)) bus ();

    assign bus.btn_n     = btn_drv;
    assign bus.clear_req = clear_drv;

    btn_event_capture #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (WIN),
        .CNT_W           (4)
    ) dut (
        .ti_clk (ti_clk),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s @%0t got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Drive inputs at a falling edge and hold them for n rising edges
    task automatic applyStimulus(input logic [3:0] b, input logic c, input int n);
        btn_drv   = b;
        clear_drv = c;
        repeat (n) @(negedge ti_clk);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge ti_clk);
        reset = 1'b0;
    endtask

    // Reference model: a button flips once the last WIN synchronised samples
    // (raw input delayed two edges) all disagree with its current stable value
    initial begin
        forever begin
            @(posedge ti_clk);
            if (reset) begin
                m_armed    = 1;
                raw_q.delete();
                m_stable   = 4'h0;
                m_sticky   = 4'h0;
                m_cnt      = 8'h00;
                m_clr_prev = 1'b0;
                exp_q.push_back(16'h0000);
            end else if (m_armed) begin
                raw_q.push_back(btn_drv);
                n_raw  = raw_q.size();
                m_flip = 4'h0;
                for (int i = 0; i < 4; i++) begin
                    all_diff = 1;
                    for (int k = 0; k < WIN; k++) begin
                        idx = n_raw - 3 - k;
                        if (idx < 0) all_diff = 0;
                        else if ((!raw_q[idx][i]) == m_stable[i]) all_diff = 0;
                    end
                    m_flip[i] = all_diff;
                end
`ifdef BTN_RELEASE_EVENT_EN
                m_evt = m_flip;
`else
                m_evt = m_flip & ~m_stable;
`endif
                m_stable = m_stable ^ m_flip;
                if (clear_drv && !m_clr_prev) begin
                    m_sticky = 4'h0;
                    m_cnt    = 8'h00;
                end
                m_clr_prev = clear_drv;
                m_sticky   = m_sticky | m_evt;
                m_cnt      = m_cnt + 8'($countones(m_evt));
                exp_q.push_back({m_cnt, m_sticky, m_stable});
                while (raw_q.size() > 16) void'(raw_q.pop_front());
            end
        end
    end

    // Monitor: compares the DUT outputs against the oldest prediction each cycle
    initial begin
        forever begin
            @(posedge ti_clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("status_word", bus.status_word, mon_exp);
                checkOutput("stable", {12'h000, bus.stable}, {12'h000, mon_exp[3:0]});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        btn_drv   = 4'hF;
        clear_drv = 1'b0;
        repeat (2) @(negedge ti_clk);
        reset = 1'b0;
        checkOutput("reset_status", bus.status_word, 16'h0000);
        applyStimulus(4'hF, 1'b0, 5);
        checkOutput("idle_status", bus.status_word, 16'h0000);

        $display("[TB] single press on button 0");
        applyStimulus(4'hE, 1'b0, 9);
        checkOutput("press_edge9", bus.status_word, 16'h0000);
        applyStimulus(4'hE, 1'b0, 1);
        checkOutput("press_edge10", bus.status_word, 16'h0111);

        $display("[TB] 7-cycle glitch on button 1");
        applyStimulus(4'hC, 1'b0, 7);
        applyStimulus(4'hE, 1'b0, 12);
        checkOutput("glitch_rejected", bus.status_word, 16'h0111);

        $display("[TB] buttons 2 and 3 together");
        applyStimulus(4'h2, 1'b0, 12);
        checkOutput("pair_press", bus.status_word, 16'h03DD);
        applyStimulus(4'hE, 1'b0, 12);
`ifdef BTN_RELEASE_EVENT_EN
        checkOutput("pair_release", bus.status_word, 16'h05D1);
`else
        checkOutput("pair_release", bus.status_word, 16'h03D1);
`endif

        $display("[TB] clear coinciding with press event");
        applyStimulus(4'hF, 1'b0, 12);
        applyStimulus(4'hE, 1'b0, 9);
        applyStimulus(4'hE, 1'b1, 1);
        checkOutput("clear_vs_event", bus.status_word, 16'h0111);
        applyStimulus(4'hE, 1'b1, 20);
        checkOutput("clear_held", bus.status_word, 16'h0111);
        applyStimulus(4'hE, 1'b0, 2);

        $display("[TB] counter wrap over 256 presses");
        applyStimulus(4'hF, 1'b0, 12);
        applyStimulus(4'hF, 1'b1, 1);
        applyStimulus(4'hF, 1'b0, 1);
        checkOutput("cleared", bus.status_word, 16'h0000);
        for (int p = 0; p < 256; p++) begin
            applyStimulus(4'hE, 1'b0, 12);
            applyStimulus(4'hF, 1'b0, 12);
        end
        checkOutput("cnt_wrap", bus.status_word, 16'h0010);

        $display("[TB] randomized traffic");
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 24) == 0) pulseReset();
            applyStimulus(4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0),
                          $urandom_range(1, 14));
        end

        applyStimulus(4'hF, 1'b0, 3);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge ti_clk);
        if (exp_q.size() > 0) begin
            miss_count++;
            $display("[TB] FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
